dsky_key_encoder: RTL and testbench

//  Upstream of the A18 input/interrupt stage: scans one DSKY's raw key switch contacts, debounces them,

---
 rtl/dsky_pkg.sv | 48 ++++
 rtl/dsky_debounce.sv | 59 +++++
 rtl/dsky_key_encoder.sv | 179 +++++++++++++++++
 tb/tb_dsky_key_encoder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsky_pkg.sv
// Shared definitions for the DSKY key encoder: key indices, state encoding
// and the key-index to 5-bit key-code ROM.
package dsky_pkg;

    localparam int KEY_COUNT = 18;
    localparam int IDX_W     = 5;

    localparam int KEY_VERB  = 10;
    localparam int KEY_NOUN  = 11;
    localparam int KEY_PLUS  = 12;
    localparam int KEY_MINUS = 13;
    localparam int KEY_CLR   = 14;
    localparam int KEY_REL   = 15;
    localparam int KEY_ENTR  = 16;
    localparam int KEY_RSET  = 17;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REL_DB   = 3'd3,
        LOCKOUT  = 3'd4
    } key_state_e;

    // Codes are octal as read on the DSKY; code 00 is reserved for "no key".
    function automatic logic [4:0] key_code(input logic [IDX_W-1:0] idx);
        logic [4:0] code;
        code = 5'o00;
        if (idx >= 5'd1 && idx <= 5'd9) begin
            code = idx;
        end else begin
            case (idx)
                5'd0:            code = 5'o20;
                5'(KEY_VERB):    code = 5'o21;
                5'(KEY_NOUN):    code = 5'o37;
                5'(KEY_PLUS):    code = 5'o32;
                5'(KEY_MINUS):   code = 5'o33;
                5'(KEY_CLR):     code = 5'o36;
                5'(KEY_REL):     code = 5'o31;
                5'(KEY_ENTR):    code = 5'o34;
                5'(KEY_RSET):    code = 5'o22;
                default:         code = 5'o00;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/dsky_debounce.sv
// Single-contact debouncer: 2-flop synchroniser followed by a TICK-driven
// agreement counter; the output flips only after a sustained difference.
module dsky_debounce
    import dsky_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic db_o
);

    localparam logic [CNT_W-1:0] TICKS_C = CNT_W'(DEBOUNCE_TICKS);

    logic             meta_q;
    logic             sync_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    // Any TICK on which the contact agrees with the output restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (tick_i) begin
            if (sync_q != db_q) begin
                if (cnt_q >= TICKS_C - CNT_W'(1)) begin
                    db_d  = sync_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/dsky_key_encoder.sv
// DSKY key encoder: synchronises the 18 key contacts, debounces a single key
// with multi-key lockout, and drives the registered 5-bit key code plus PRO.
module dsky_key_encoder
    import dsky_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 TICK,
    input  logic [KEY_COUNT-1:0] KEYSW,
    input  logic                 PROSW,
    output logic                 KEY1,
    output logic                 KEY2,
    output logic                 KEY3,
    output logic                 KEY4,
    output logic                 KEY5,
    output logic                 SBYBUT,
    output logic                 LOCKED
);

    localparam logic [CNT_W-1:0] TICKS_C = CNT_W'(DEBOUNCE_TICKS);

    logic [KEY_COUNT-1:0] keysw_meta_q;
    logic [KEY_COUNT-1:0] keysw_sync_q;

    key_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4:0]           code_q, code_d;
    logic                 locked_q, locked_d;

    logic [4:0]           n_keys;
    logic [IDX_W-1:0]     sel_idx;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 none, same, multi_or_other;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keysw_meta_q <= '0;
            keysw_sync_q <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            code_q       <= '0;
            locked_q     <= 1'b0;
        end else begin
            keysw_meta_q <= KEYSW;
            keysw_sync_q <= keysw_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            locked_q     <= locked_d;
        end
    end

    always_comb begin
        n_keys  = '0;
        sel_idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            n_keys = n_keys + 5'(keysw_sync_q[i]);
        end
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (keysw_sync_q[i]) sel_idx = IDX_W'(i);
        end
    end

    assign none           = (n_keys == 5'd0);
    assign same           = (n_keys == 5'd1) && (sel_idx == idx_q);
    assign multi_or_other = !none && !same;
    assign cnt_inc        = (cnt_q >= TICKS_C) ? TICKS_C : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        code_d  = code_q;
        if (TICK) begin
            case (state_q)
                IDLE: begin
                    if (n_keys == 5'd1) begin
                        idx_d   = sel_idx;
                        state_d = PRESS_DB;
                        cnt_d   = CNT_W'(1);
                        if (TICKS_C == CNT_W'(1)) begin
                            state_d = HELD;
                            code_d  = key_code(sel_idx);
                            cnt_d   = '0;
                        end
                    end else if (!none) begin
                        state_d = LOCKOUT;
                        cnt_d   = '0;
                    end
                end
                PRESS_DB: begin
                    if (same) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TICKS_C) begin
                            state_d = HELD;
                            code_d  = key_code(idx_q);
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = (n_keys >= 5'd2) ? LOCKOUT : IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (none) begin
                        state_d = REL_DB;
                        cnt_d   = CNT_W'(1);
                        if (TICKS_C == CNT_W'(1)) begin
                            state_d = IDLE;
                            code_d  = '0;
                            cnt_d   = '0;
                        end
                    end else if (multi_or_other) begin
                        state_d = LOCKOUT;
                        code_d  = '0;
                        cnt_d   = '0;
                    end
                end
                REL_DB: begin
                    if (none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TICKS_C) begin
                            state_d = IDLE;
                            code_d  = '0;
                            cnt_d   = '0;
                        end
                    end else if (same) begin
                        // Contact bounce on release: resume holding the same code.
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOCKOUT;
                        code_d  = '0;
                        cnt_d   = '0;
                    end
                end
                LOCKOUT: begin
                    code_d = '0;
                    if (none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TICKS_C) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    code_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == LOCKOUT);
    end

    dsky_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .CNT_W         (CNT_W)
    ) u_pro_db (
        .clk   (clk),
        .rst   (rst),
        .tick_i(TICK),
        .raw_i (PROSW),
        .db_o  (SBYBUT)
    );

    assign {KEY5, KEY4, KEY3, KEY2, KEY1} = code_q;
    assign LOCKED = locked_q;

endmodule

// File: tb/tb_dsky_key_encoder.sv
// Bench for dsky_key_encoder: TICK every 4 clk, key-code and SBYBUT change
// scoreboards plus per-scenario timing and state checks.
module tb_dsky_key_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        TICK;
    logic [17:0] KEYSW;
    logic        PROSW;
    logic        KEY1, KEY2, KEY3, KEY4, KEY5;
    logic        SBYBUT;
    logic        LOCKED;
    logic [4:0]  code;

    int checks   = 0;
    int failures = 0;
    int tcnt     = 0;

    logic [4:0] exp_q[$];
    logic       sby_q[$];
    logic [4:0] prev_code = 5'o00;
    logic       prev_sby  = 1'b0;

    dsky_key_encoder #(.DEBOUNCE_TICKS(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .TICK  (TICK),
        .KEYSW (KEYSW),
        .PROSW (PROSW),
        .KEY1  (KEY1),
        .KEY2  (KEY2),
        .KEY3  (KEY3),
        .KEY4  (KEY4),
        .KEY5  (KEY5),
        .SBYBUT(SBYBUT),
        .LOCKED(LOCKED)
    );

    assign code = {KEY5, KEY4, KEY3, KEY2, KEY1};

    always #5 clk = ~clk;

    initial begin
        TICK = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            TICK = (tcnt == 0);
        end
    end

    // Every change of the key code or SBYBUT must match the next queued expectation.
    always @(posedge clk) begin : monitor
        logic [4:0] e;
        logic       es;
        #1;
        if (code !== prev_code) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL code_seq: unexpected code change to %o, nothing pending", code);
            end else begin
                e = exp_q.pop_front();
                if (code !== e) begin
                    failures++;
                    $display("FAIL code_seq: code=%o required=%o", code, e);
                end
            end
            prev_code = code;
        end
        if (SBYBUT !== prev_sby) begin
            checks++;
            if (sby_q.size() == 0) begin
                failures++;
                $display("FAIL sby_seq: unexpected SBYBUT change to %b", SBYBUT);
            end else begin
                es = sby_q.pop_front();
                if (SBYBUT !== es) begin
                    failures++;
                    $display("FAIL sby_seq: SBYBUT=%b required=%b", SBYBUT, es);
                end
            end
            prev_sby = SBYBUT;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (TICK !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic wait_code(input logic [4:0] exp, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(posedge clk);
            #1;
            if (code === exp) ok = 1'b1;
        end
    endtask

    // Counts TICK edges that see the new synchronised input (3rd clk onward) until code==exp.
    task automatic ticks_until(input logic [4:0] exp, input int max_cyc, output int nt, output bit ok);
        int e;
        nt = 0;
        ok = 1'b0;
        e  = 0;
        while (!ok && e < max_cyc) begin
            @(posedge clk);
            e++;
            if (TICK && e >= 3) nt++;
            #1;
            if (code === exp) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (code !== 5'o00 || SBYBUT !== 1'b0 || LOCKED !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: code=%o sby=%b locked=%b required 00/0/0", code, SBYBUT, LOCKED);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (code !== 5'o00 || SBYBUT !== 1'b0 || LOCKED !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: code=%o sby=%b locked=%b required 00/0/0", code, SBYBUT, LOCKED);
        end
    endtask

    task automatic test_single_press;
        int nt;
        bit ok;
        @(negedge clk);
        KEYSW = 18'h0_0020;
        exp_q.push_back(5'o05);
        ticks_until(5'o05, 60, nt, ok);
        checks++;
        if (!ok || nt != 4) begin
            failures++;
            $display("FAIL press_latency: ok=%0d ticks=%0d required ticks=4", ok, nt);
        end
        wait_ticks(3);
        @(negedge clk);
        KEYSW = '0;
        exp_q.push_back(5'o00);
        ticks_until(5'o00, 60, nt, ok);
        checks++;
        if (!ok || nt != 4) begin
            failures++;
            $display("FAIL release_latency: ok=%0d ticks=%0d required ticks=4", ok, nt);
        end
    endtask

    task automatic test_bounce_press;
        int nt;
        bit ok;
        @(negedge clk);
        KEYSW = 18'h0_0400;
        wait_ticks(2);
        @(negedge clk);
        KEYSW = '0;
        wait_ticks(1);
        #1;
        checks++;
        if (code !== 5'o00) begin
            failures++;
            $display("FAIL bounce_no_early_code: code=%o required=00", code);
        end
        @(negedge clk);
        KEYSW = 18'h0_0400;
        exp_q.push_back(5'o21);
        ticks_until(5'o21, 60, nt, ok);
        checks++;
        if (!ok || nt != 4) begin
            failures++;
            $display("FAIL bounce_latency: ok=%0d ticks=%0d required ticks=4", ok, nt);
        end
        wait_ticks(8);
        @(negedge clk);
        KEYSW = '0;
        exp_q.push_back(5'o00);
        wait_code(5'o00, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bounce_release: code=%o required=00", code);
        end
    endtask

    task automatic test_lockout;
        int nt;
        bit ok;
        @(negedge clk);
        KEYSW = 18'h0_0800;
        exp_q.push_back(5'o37);
        wait_code(5'o37, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL noun_code: code=%o required=37", code);
        end
        @(negedge clk);
        KEYSW = 18'h0_0801;
        exp_q.push_back(5'o00);
        wait_ticks(2);
        #1;
        checks++;
        if (code !== 5'o00 || LOCKED !== 1'b1) begin
            failures++;
            $display("FAIL lockout_entry: code=%o locked=%b required 00/1", code, LOCKED);
        end
        @(negedge clk);
        KEYSW = 18'h0_0001;
        wait_ticks(6);
        #1;
        checks++;
        if (code !== 5'o00 || LOCKED !== 1'b1) begin
            failures++;
            $display("FAIL lockout_partial_release: code=%o locked=%b required 00/1", code, LOCKED);
        end
        @(negedge clk);
        KEYSW = '0;
        wait_ticks(3);
        #1;
        checks++;
        if (LOCKED !== 1'b1) begin
            failures++;
            $display("FAIL lockout_hold_3ticks: locked=%b required=1", LOCKED);
        end
        wait_ticks(3);
        #1;
        checks++;
        if (LOCKED !== 1'b0) begin
            failures++;
            $display("FAIL lockout_exit: locked=%b required=0", LOCKED);
        end
        @(negedge clk);
        KEYSW = 18'h0_0080;
        exp_q.push_back(5'o07);
        ticks_until(5'o07, 60, nt, ok);
        checks++;
        if (!ok || nt != 4) begin
            failures++;
            $display("FAIL after_lockout_press: ok=%0d ticks=%0d required ticks=4", ok, nt);
        end
        @(negedge clk);
        KEYSW = '0;
        exp_q.push_back(5'o00);
        wait_code(5'o00, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL after_lockout_release: code=%o required=00", code);
        end
    endtask

    task automatic test_release_bounce;
        bit ok;
        bit bad;
        logic [4:0] seen;
        @(negedge clk);
        KEYSW = 18'h0_0001;
        exp_q.push_back(5'o20);
        wait_code(5'o20, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL digit0_code: code=%o required=20", code);
        end
        @(negedge clk);
        KEYSW = '0;
        bad  = 1'b0;
        seen = 5'o20;
        repeat (8) begin
            @(negedge clk);
            if (code !== 5'o20) begin bad = 1'b1; seen = code; end
        end
        KEYSW = 18'h0_0001;
        repeat (20) begin
            @(negedge clk);
            if (code !== 5'o20) begin bad = 1'b1; seen = code; end
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rel_bounce_steady: code=%o required=20", seen);
        end
        KEYSW = '0;
        exp_q.push_back(5'o00);
        wait_code(5'o00, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL digit0_release: code=%o required=00", code);
        end
    endtask

    task automatic test_pro;
        bit ok;
        bit bad;
        @(negedge clk);
        KEYSW = 18'h0_0008;
        exp_q.push_back(5'o03);
        wait_code(5'o03, 60, ok);
        @(negedge clk);
        PROSW = 1'b1;
        sby_q.push_back(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (SBYBUT === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || code !== 5'o03) begin
            failures++;
            $display("FAIL pro_press: sby=%b code=%o required 1/03", SBYBUT, code);
        end
        @(negedge clk);
        PROSW = 1'b0;
        repeat (12) @(negedge clk);
        PROSW = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (SBYBUT !== 1'b1 || code !== 5'o03) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL pro_glitch: sby=%b code=%o required 1/03", SBYBUT, code);
        end
        PROSW = 1'b0;
        sby_q.push_back(1'b0);
        KEYSW = '0;
        exp_q.push_back(5'o00);
        repeat (40) @(negedge clk);
        checks++;
        if (SBYBUT !== 1'b0 || code !== 5'o00) begin
            failures++;
            $display("FAIL pro_release: sby=%b code=%o required 0/00", SBYBUT, code);
        end
    endtask

    task automatic test_reset_mid_press;
        int nt;
        bit ok;
        @(negedge clk);
        KEYSW = 18'h1_0000;
        exp_q.push_back(5'o34);
        wait_code(5'o34, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL entr_code: code=%o required=34", code);
        end
        @(negedge clk);
        exp_q.push_back(5'o00);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (code !== 5'o00 || SBYBUT !== 1'b0 || LOCKED !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: code=%o sby=%b locked=%b required 00/0/0", code, SBYBUT, LOCKED);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(5'o34);
        ticks_until(5'o34, 60, nt, ok);
        checks++;
        if (!ok || nt != 4) begin
            failures++;
            $display("FAIL post_reset_redebounce: ok=%0d ticks=%0d required ticks=4", ok, nt);
        end
        @(negedge clk);
        KEYSW = '0;
        exp_q.push_back(5'o00);
        wait_code(5'o00, 60, ok);
    endtask

    initial begin
        rst   = 1'b1;
        KEYSW = '0;
        PROSW = 1'b0;
        #2;
        rst = 1'b0;
        test_reset();
        test_single_press();
        test_bounce_press();
        test_lockout();
        test_release_bounce();
        test_pro();
        test_reset_mid_press();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || sby_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending code=%0d sby=%0d required 0/0", exp_q.size(), sby_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
